gpib_acceptor_handshake: RTL

Listener-side acceptor handshake (AH) stage, directly downstream of the GPIB interface block.
- While that block reports listener active and ATN is deasserted, this block runs the three-wire DAV/NRFD/NDAC handshake.
- Each data byte and its EOI flag are captured into a small byte FIFO for the device core.
- Provides back-pressure (holds NRFD when the FIFO is full) and a DAV-stuck timeout error.

---
 rtl/gpib_acceptor_handshake.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/gpib_acceptor_handshake.sv
// GPIB listener acceptor handshake: synchronises DAV/ATN/EOI, runs the NRFD/NDAC
// interlock, captures bytes into a show-ahead FIFO and flags a stuck-DAV timeout.
//
// state  | meaning
// IDLE   | lines released (nrfd=0, ndac=0); not listening or ATN active
// BUSY   | FIFO full, holding off the talker (nrfd=1, ndac=1)
// READY  | ready for data, waiting for DAV (nrfd=0, ndac=1)
// ACCEPT | byte captured, waiting for DAV release (nrfd=1, ndac=0)
module gpib_acceptor_handshake #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          listener_en,
   input  logic                          atn,
   input  logic                          dav,
   input  logic                          eoi,
   input  logic [DATA_WIDTH-1:0]         gpib_data,
   output logic                          nrfd_o,
   output logic                          ndac_o,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_eoi,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          timeout_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_READY  = 2'd2,
      ST_ACCEPT = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] dav_sync_q, dav_sync_d;
   logic [SYNC_STAGES-1:0] atn_sync_q, atn_sync_d;
   logic [SYNC_STAGES-1:0] eoi_sync_q, eoi_sync_d;
   logic                   dav_s, atn_s, eoi_s, rx_ok;

   state_t                 state_q, state_d;
   logic                   nrfd_q, nrfd_d;
   logic                   ndac_q, ndac_d;
   logic                   tout_q, tout_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic                   push, pop;

   logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   full_w, empty_w;

   always_comb begin
      dav_sync_d = {dav_sync_q[SYNC_STAGES-2:0], dav};
      atn_sync_d = {atn_sync_q[SYNC_STAGES-2:0], atn};
      eoi_sync_d = {eoi_sync_q[SYNC_STAGES-2:0], eoi};
   end

   assign dav_s   = dav_sync_q[SYNC_STAGES-1];
   assign atn_s   = atn_sync_q[SYNC_STAGES-1];
   assign eoi_s   = eoi_sync_q[SYNC_STAGES-1];
   assign rx_ok   = listener_en & ~atn_s;
   assign full_w  = (count_q == FULL_LVL);
   assign empty_w = (count_q == '0);

   // Handshake outputs are registered alongside the state so they change on the transition edge.
   always_comb begin
      state_d = state_q;
      nrfd_d  = nrfd_q;
      ndac_d  = ndac_q;
      tmr_d   = tmr_q;
      tout_d  = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_ok && !full_w) begin
               state_d = ST_READY;  nrfd_d = 1'b0; ndac_d = 1'b1;
            end else if (rx_ok) begin
               state_d = ST_BUSY;   nrfd_d = 1'b1; ndac_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (!rx_ok) begin
               state_d = ST_IDLE;   nrfd_d = 1'b0; ndac_d = 1'b0;
            end else if (!full_w) begin
               state_d = ST_READY;  nrfd_d = 1'b0; ndac_d = 1'b1;
            end
         end
         ST_READY: begin
            if (!rx_ok) begin
               state_d = ST_IDLE;   nrfd_d = 1'b0; ndac_d = 1'b0;
            end else if (dav_s) begin
               state_d = ST_ACCEPT; nrfd_d = 1'b1; ndac_d = 1'b0;
               push    = 1'b1;
               tmr_d   = TMR_LOAD;
            end
         end
         ST_ACCEPT: begin
            // rx_ok is only consulted after DAV releases so the talker's cycle always completes.
            if (!dav_s) begin
               if (rx_ok && !full_w) begin
                  state_d = ST_READY; nrfd_d = 1'b0; ndac_d = 1'b1;
               end else if (rx_ok) begin
                  state_d = ST_BUSY;  nrfd_d = 1'b1; ndac_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;  nrfd_d = 1'b0; ndac_d = 1'b0;
               end
            end else if (tmr_q == '0) begin
               state_d = ST_IDLE;   nrfd_d = 1'b0; ndac_d = 1'b0;
               tout_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      pop      = rd_en & ~empty_w;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dav_sync_q <= '0;
         atn_sync_q <= '0;
         eoi_sync_q <= '0;
         state_q    <= ST_IDLE;
         nrfd_q     <= 1'b0;
         ndac_q     <= 1'b0;
         tout_q     <= 1'b0;
         tmr_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         dav_sync_q <= dav_sync_d;
         atn_sync_q <= atn_sync_d;
         eoi_sync_q <= eoi_sync_d;
         state_q    <= state_d;
         nrfd_q     <= nrfd_d;
         ndac_q     <= ndac_d;
         tout_q     <= tout_d;
         tmr_q      <= tmr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {eoi_s, gpib_data};
   end

   assign rd_data     = empty_w ? '0   : mem_q[rd_ptr_q][DATA_WIDTH-1:0];
   assign rd_eoi      = empty_w ? 1'b0 : mem_q[rd_ptr_q][DATA_WIDTH];
   assign empty       = empty_w;
   assign full        = full_w;
   assign count       = count_q;
   assign nrfd_o      = nrfd_q;
   assign ndac_o      = ndac_q;
   assign timeout_err = tout_q;

endmodule
